iob_sfifo_asym: RTL and testbench



---
 rtl/iob_sfifo_asym_pkg.sv | 31 +++
 rtl/iob_sfifo_asym_mem.sv | 41 ++++
 rtl/iob_sfifo_asym.sv | 89 ++++++++
 tb/tb_iob_sfifo_asym.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_sfifo_asym_pkg.sv
// Shared helpers for the asymmetric-width FIFO: width arithmetic used to derive
// the unit width, write/read steps and depth from the top-level parameters.
package iob_sfifo_asym_pkg;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int min_of(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Storage unit U: the narrower of the two port widths.
    function automatic int unit_w(input int w_w, input int r_w);
        return min_of(w_w, r_w);
    endfunction

    // Units moved per access on a port of width port_w (WS or RS).
    function automatic int step_of(input int port_w, input int w_w, input int r_w);
        return port_w / unit_w(w_w, r_w);
    endfunction

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic bit is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

endpackage

// File: rtl/iob_sfifo_asym_mem.sv
// Register-array storage in narrow units: WS-unit write port and a registered
// RS-unit read port, both at step-aligned addresses, little-endian unit order.
module iob_sfifo_asym_mem #(
    parameter int U_W    = 8,
    parameter int ADDR_W = 6,
    parameter int WS     = 4,
    parameter int RS     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [ADDR_W-1:0]   wptr,
    input  logic [WS*U_W-1:0]   wdata,
    input  logic                re,
    input  logic [ADDR_W-1:0]   rptr,
    output logic [RS*U_W-1:0]   rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [U_W-1:0] mem [DEPTH];

    // Pointers are always multiples of the step, so unit offsets never wrap.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < WS; k++) begin
                mem[wptr + ADDR_W'(k)] <= wdata[k*U_W +: U_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            for (int k = 0; k < RS; k++) begin
                rdata[k*U_W +: U_W] <= mem[rptr + ADDR_W'(k)];
            end
        end
    end

endmodule

// File: rtl/iob_sfifo_asym.sv
// Single-clock FIFO with independent write/read widths; occupancy is tracked in
// narrow units and drives full/empty, programmable almost flags and sticky errors.
module iob_sfifo_asym
    import iob_sfifo_asym_pkg::*;
#(
    parameter int W_DATA_W   = 32,
    parameter int R_DATA_W   = 8,
    parameter int ADDR_W     = 6,
    parameter int AFULL_LVL  = (1 << ADDR_W) - 8,
    parameter int AEMPTY_LVL = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [W_DATA_W-1:0] data_in,
    input  logic                write_en,
    output logic                full,
    output logic [R_DATA_W-1:0] data_out,
    input  logic                read_en,
    output logic                empty,
    output logic [ADDR_W:0]     level,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                overflow,
    output logic                underflow
);
    localparam int U     = unit_w(W_DATA_W, R_DATA_W);
    localparam int WS    = step_of(W_DATA_W, W_DATA_W, R_DATA_W);
    localparam int RS    = step_of(R_DATA_W, W_DATA_W, R_DATA_W);
    localparam int DEPTH = depth_of(ADDR_W);
    localparam int RATIO = max_of(W_DATA_W, R_DATA_W) / U;
    localparam int LW    = ADDR_W + 1;

    localparam logic [LW-1:0]     WS_L   = LW'(WS);
    localparam logic [LW-1:0]     RS_L   = LW'(RS);
    localparam logic [LW-1:0]     FULL_L = LW'(DEPTH - WS);
    localparam logic [ADDR_W-1:0] WS_A   = ADDR_W'(WS);
    localparam logic [ADDR_W-1:0] RS_A   = ADDR_W'(RS);

    if (!is_pow2(RATIO) || (DEPTH < RATIO)) begin : g_bad_cfg
        $error("iob_sfifo_asym: width ratio must be a power of two no larger than DEPTH");
    end

    logic [ADDR_W-1:0] wptr, rptr;
    logic [LW-1:0]     level_q;
    logic              wa, ra;

    assign full         = level_q > FULL_L;
    assign empty        = level_q < RS_L;
    assign wa           = write_en & ~full;
    assign ra           = read_en & ~empty;
    assign level        = level_q;
    assign almost_full  = 32'(level_q) >= 32'(AFULL_LVL);
    assign almost_empty = 32'(level_q) <= 32'(AEMPTY_LVL);

    // Both terms apply on a simultaneous read and write; the guards on wa/ra
    // keep the result inside 0..DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            level_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wa) wptr <= wptr + WS_A;
            if (ra) rptr <= rptr + RS_A;
            level_q   <= level_q + (wa ? WS_L : '0) - (ra ? RS_L : '0);
            overflow  <= overflow  | (write_en & full);
            underflow <= underflow | (read_en & empty);
        end
    end

    iob_sfifo_asym_mem #(
        .U_W    (U),
        .ADDR_W (ADDR_W),
        .WS     (WS),
        .RS     (RS)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wa),
        .wptr  (wptr),
        .wdata (data_in),
        .re    (ra),
        .rptr  (rptr),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_iob_sfifo_asym.sv
// Bench for iob_sfifo_asym: three instances (8->32, 32->8, 16->16, depth 16)
// checked against a unit-queue reference model, directed table plus random streams.
module tb_iob_sfifo_asym;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din [3];
    logic [2:0]  we, re;
    logic [31:0] dout [3];
    logic [31:0] dout0;
    logic [7:0]  dout1;
    logic [15:0] dout2;
    logic [4:0]  lvl [3];
    logic [2:0]  full, empty, af, ae, ovf, unf;

    always #5 clk = ~clk;

    iob_sfifo_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(din[0][7:0]), .write_en(we[0]), .full(full[0]),
        .data_out(dout0), .read_en(re[0]), .empty(empty[0]), .level(lvl[0]),
        .almost_full(af[0]), .almost_empty(ae[0]), .overflow(ovf[0]), .underflow(unf[0]));

    iob_sfifo_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(din[1]), .write_en(we[1]), .full(full[1]),
        .data_out(dout1), .read_en(re[1]), .empty(empty[1]), .level(lvl[1]),
        .almost_full(af[1]), .almost_empty(ae[1]), .overflow(ovf[1]), .underflow(unf[1]));

    iob_sfifo_asym #(.W_DATA_W(16), .R_DATA_W(16), .ADDR_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .data_in(din[2][15:0]), .write_en(we[2]), .full(full[2]),
        .data_out(dout2), .read_en(re[2]), .empty(empty[2]), .level(lvl[2]),
        .almost_full(af[2]), .almost_empty(ae[2]), .overflow(ovf[2]), .underflow(unf[2]));

    assign dout[0] = dout0;
    assign dout[1] = {24'h0, dout1};
    assign dout[2] = {16'h0, dout2};

    // Reference model: a queue of narrow units per instance, oldest at the front.
    logic [15:0] mq [3][$];
    logic [31:0] exp_dout [3];
    bit          exp_ovf [3];
    bit          exp_unf [3];
    int          uw [3] = '{8, 8, 16};
    int          ws [3] = '{1, 4, 1};
    int          rs [3] = '{4, 1, 1};
    int          nwr [3];
    int          nchk = 0;
    int          npass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_state(input int i);
        int sz = mq[i].size();
        check($sformatf("level%0d", i), 32'(lvl[i]), sz);
        check($sformatf("empty%0d", i), 32'(empty[i]), 32'(sz < rs[i]));
        check($sformatf("full%0d", i), 32'(full[i]), 32'(sz > DEPTH - ws[i]));
        check($sformatf("afull%0d", i), 32'(af[i]), 32'(sz >= DEPTH - 8));
        check($sformatf("aempty%0d", i), 32'(ae[i]), 32'(sz <= 8));
        check($sformatf("dout%0d", i), dout[i], exp_dout[i]);
        check($sformatf("ovf%0d", i), 32'(ovf[i]), 32'(exp_ovf[i]));
        check($sformatf("unf%0d", i), 32'(unf[i]), 32'(exp_unf[i]));
    endtask

    // One clock: decide acceptance from pre-edge model state, then update and compare.
    task automatic tick();
        bit          wa [3];
        bit          ra [3];
        logic [31:0] wd [3];
        for (int i = 0; i < 3; i++) begin
            int sz = mq[i].size();
            bit f = sz > DEPTH - ws[i];
            bit e = sz < rs[i];
            wa[i] = we[i] && !f;
            ra[i] = re[i] && !e;
            wd[i] = din[i];
            if (we[i] && f) exp_ovf[i] = 1'b1;
            if (re[i] && e) exp_unf[i] = 1'b1;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] mask = (32'h1 << uw[i]) - 32'h1;
            if (ra[i]) begin
                logic [31:0] v = '0;
                for (int k = 0; k < rs[i]; k++) v |= 32'(mq[i].pop_front()) << (k * uw[i]);
                exp_dout[i] = v;
            end
            if (wa[i]) begin
                for (int k = 0; k < ws[i]; k++) mq[i].push_back(16'((wd[i] >> (k * uw[i])) & mask));
                nwr[i]++;
            end
            check_state(i);
        end
    endtask

    task automatic idle_inputs();
        we = '0;
        re = '0;
        for (int i = 0; i < 3; i++) din[i] = '0;
    endtask

    typedef struct {
        int          idx;
        bit          w;
        bit          r;
        logic [31:0] d;
        int          lv;
        bit          e;
        bit          f;
        logic [31:0] q;
        logic [1:0]  err;
    } vec_t;

    vec_t tv [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            exp_dout[i] = '0;
            exp_ovf[i]  = 1'b0;
            exp_unf[i]  = 1'b0;
            nwr[i]      = 0;
        end
        #1;
        for (int i = 0; i < 3; i++) check_state(i);
        #11 rst_n = 1'b1;

        // 8->32 assembly, 32->8 split, full/overflow boundary, simultaneous rd/wr, underflow.
        tv.push_back('{0, 1, 0, 32'h11, 1, 1, 0, 32'h0, 2'b00});
        tv.push_back('{0, 1, 0, 32'h22, 2, 1, 0, 32'h0, 2'b00});
        tv.push_back('{0, 1, 0, 32'h33, 3, 1, 0, 32'h0, 2'b00});
        tv.push_back('{0, 1, 0, 32'h44, 4, 0, 0, 32'h0, 2'b00});
        tv.push_back('{0, 0, 1, 32'h0, 0, 1, 0, 32'h44332211, 2'b00});
        tv.push_back('{1, 1, 0, 32'hA1B2C3D4, 4, 0, 0, 32'h0, 2'b00});
        tv.push_back('{1, 0, 1, 32'h0, 3, 0, 0, 32'hD4, 2'b00});
        tv.push_back('{1, 0, 1, 32'h0, 2, 0, 0, 32'hC3, 2'b00});
        tv.push_back('{1, 0, 1, 32'h0, 1, 0, 0, 32'hB2, 2'b00});
        tv.push_back('{1, 0, 1, 32'h0, 0, 1, 0, 32'hA1, 2'b00});
        tv.push_back('{1, 1, 0, 32'h03020100, 4, 0, 0, 32'hA1, 2'b00});
        tv.push_back('{1, 1, 0, 32'h07060504, 8, 0, 0, 32'hA1, 2'b00});
        tv.push_back('{1, 1, 0, 32'h0B0A0908, 12, 0, 0, 32'hA1, 2'b00});
        tv.push_back('{1, 1, 0, 32'h0F0E0D0C, 16, 0, 1, 32'hA1, 2'b00});
        tv.push_back('{1, 1, 0, 32'hDEADBEEF, 16, 0, 1, 32'hA1, 2'b10});
        tv.push_back('{1, 0, 1, 32'h0, 15, 0, 1, 32'h00, 2'b10});
        tv.push_back('{1, 0, 1, 32'h0, 14, 0, 1, 32'h01, 2'b10});
        tv.push_back('{1, 0, 1, 32'h0, 13, 0, 1, 32'h02, 2'b10});
        tv.push_back('{1, 0, 1, 32'h0, 12, 0, 0, 32'h03, 2'b10});
        tv.push_back('{0, 1, 0, 32'h01, 1, 1, 0, 32'h44332211, 2'b00});
        tv.push_back('{0, 1, 0, 32'h02, 2, 1, 0, 32'h44332211, 2'b00});
        tv.push_back('{0, 1, 0, 32'h03, 3, 1, 0, 32'h44332211, 2'b00});
        tv.push_back('{0, 1, 0, 32'h04, 4, 0, 0, 32'h44332211, 2'b00});
        tv.push_back('{0, 1, 1, 32'h55, 1, 1, 0, 32'h04030201, 2'b00});
        tv.push_back('{0, 1, 0, 32'h66, 2, 1, 0, 32'h04030201, 2'b00});
        tv.push_back('{0, 1, 0, 32'h77, 3, 1, 0, 32'h04030201, 2'b00});
        tv.push_back('{0, 1, 0, 32'h88, 4, 0, 0, 32'h04030201, 2'b00});
        tv.push_back('{0, 0, 1, 32'h0, 0, 1, 0, 32'h88776655, 2'b00});
        tv.push_back('{0, 0, 1, 32'h0, 0, 1, 0, 32'h88776655, 2'b01});

        foreach (tv[n]) begin
            idle_inputs();
            we[tv[n].idx]  = tv[n].w;
            re[tv[n].idx]  = tv[n].r;
            din[tv[n].idx] = tv[n].d;
            tick();
            check($sformatf("tv%0d_level", n), 32'(lvl[tv[n].idx]), tv[n].lv);
            check($sformatf("tv%0d_empty", n), 32'(empty[tv[n].idx]), 32'(tv[n].e));
            check($sformatf("tv%0d_full", n), 32'(full[tv[n].idx]), 32'(tv[n].f));
            check($sformatf("tv%0d_dout", n), dout[tv[n].idx], tv[n].q);
            check($sformatf("tv%0d_err", n), {30'h0, ovf[tv[n].idx], unf[tv[n].idx]}, 32'(tv[n].err));
        end

        // Random streams: alternate write-heavy and read-heavy phases to hit both ends.
        begin
            int budget = 0;
            for (int i = 0; i < 3; i++) nwr[i] = 0;
            while ((nwr[0] < 100 || nwr[1] < 100 || nwr[2] < 100) && budget < 4000) begin
                bit wheavy = ((budget / 40) % 2) == 0;
                for (int i = 0; i < 3; i++) begin
                    we[i]  = $urandom_range(0, 99) < (wheavy ? 80 : 35);
                    re[i]  = $urandom_range(0, 99) < (wheavy ? 35 : 80);
                    din[i] = $urandom;
                end
                tick();
                budget++;
            end
            check("rand_budget", 32'(budget < 4000), 32'h1);
        end

        begin
            int budget = 0;
            idle_inputs();
            re = 3'b111;
            while ((!empty[0] || !empty[1] || !empty[2]) && budget < 100) begin
                tick();
                budget++;
            end
            check("drain_budget", 32'(budget < 100), 32'h1);
        end

        // Bring instance 0 to level 7, then reset between clock edges.
        begin
            int budget = 0;
            idle_inputs();
            while (mq[0].size() != 7 && budget < 20) begin
                we[0]  = (mq[0].size() < 7);
                re[0]  = (mq[0].size() > 7);
                din[0] = $urandom;
                tick();
                budget++;
            end
            check("fill7_level", 32'(lvl[0]), 32'd7);
        end
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            exp_dout[i] = '0;
            exp_ovf[i]  = 1'b0;
            exp_unf[i]  = 1'b0;
            check_state(i);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            idle_inputs();
            we[0]  = 1'b1;
            din[0] = 32'h11 * b;
            tick();
        end
        idle_inputs();
        re[0] = 1'b1;
        tick();
        check("post_reset_dout", dout[0], 32'h44332211);
        check("post_reset_level", 32'(lvl[0]), 32'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
